vector_lane_sequencer: RTL

VECTOR_LANE_SEQUENCER -- requirements
Module: vector_lane_sequencer

---
 rtl/vector_lane_sequencer_if.sv | 36 +++
 rtl/vector_lane_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vector_lane_sequencer_if.sv
`default_nettype none
// vector_lane_sequencer_if -- operand/result vectors and lane ALU handshake for the lane sequencer.
// Rev 1.0
interface vector_lane_sequencer_if #(
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int LANES = 4
);
  logic                 Start_i;
  logic [1:0]           OpType_i;
  logic [V*L-1:0]       RD1_VEC_i;
  logic [V*L-1:0]       RD2_VEC_i;
  logic [31:0]          Scalar_i;
  logic                 Lane_ready_i;
  logic                 Res_valid_i;
  logic [LANES*L-1:0]   Res_i;
  logic [LANES*L-1:0]   Vec_A_o;
  logic [LANES*L-1:0]   Vec_B_o;
  logic [1:0]           Op_o;
  logic                 Issue_valid_o;
  logic [2:0]           Beat_o;
  logic [V*L-1:0]       WD_VEC_o;
  logic                 WE_o;
  logic                 Busy_o;

  modport master (
    input  Start_i, OpType_i, RD1_VEC_i, RD2_VEC_i, Scalar_i, Lane_ready_i, Res_valid_i, Res_i,
    output Vec_A_o, Vec_B_o, Op_o, Issue_valid_o, Beat_o, WD_VEC_o, WE_o, Busy_o
  );

  modport slave (
    output Start_i, OpType_i, RD1_VEC_i, RD2_VEC_i, Scalar_i, Lane_ready_i, Res_valid_i, Res_i,
    input  Vec_A_o, Vec_B_o, Op_o, Issue_valid_o, Beat_o, WD_VEC_o, WE_o, Busy_o
  );
endinterface
`default_nettype wire

// File: rtl/vector_lane_sequencer.sv
`default_nettype none
// vector_lane_sequencer -- splits a V-element vector op into V/LANES beats for lane ALUs and reassembles results.
// Rev 1.0
module vector_lane_sequencer #(
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int LANES = 4
) (
  input wire CLK,
  input wire RST,
  vector_lane_sequencer_if.master bus
);
  localparam int BEATS = V / LANES;
  localparam int VL    = V * L;
  localparam int LW    = LANES * L;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t          state_q;
  logic [VL-1:0]   a_q, b_q, wd_q;
  logic [L-1:0]    scalar_q;
  logic [1:0]      op_q;
  logic [2:0]      beat_q, res_cnt_q;
  logic            issue_valid_q, we_q, busy_q;
  logic [LW-1:0]   vec_a_q, vec_b_q;

  logic            issue_fire, issue_last, res_fire, res_last;
  logic [2:0]      beat_d;
  logic [LW-1:0]   vec_a_d, vec_b_d;
  logic            unused_scalar_hi;

  assign unused_scalar_hi = ^bus.Scalar_i[31:L];

  // Lane k of beat b carries element b + BEATS*k.
  function automatic logic [LW-1:0] gather(input logic [VL-1:0] vec, input logic [2:0] beat);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[k*L +: L] = vec[(int'(beat) + BEATS*k)*L +: L];
    end
    return r;
  endfunction

  always_comb begin
    issue_fire = issue_valid_q && bus.Lane_ready_i;
    issue_last = issue_fire && (beat_q == 3'(BEATS-1));
    res_fire   = ((state_q == ISSUE) || (state_q == DRAIN)) && bus.Res_valid_i
                 && (res_cnt_q < 3'(BEATS));
    res_last   = res_fire && (res_cnt_q == 3'(BEATS-1));
    beat_d     = (beat_q == 3'(BEATS-1)) ? beat_q : beat_q + 3'd1;
    // Operands are registered, so precompute beat 0 from the inputs at start, else the next beat.
    if (state_q == IDLE) begin
      vec_a_d = gather(bus.RD1_VEC_i, 3'd0);
      vec_b_d = bus.OpType_i[0] ? gather(bus.RD2_VEC_i, 3'd0) : {LANES{bus.Scalar_i[L-1:0]}};
    end else begin
      vec_a_d = gather(a_q, beat_d);
      vec_b_d = op_q[0] ? gather(b_q, beat_d) : {LANES{scalar_q}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      wd_q          <= '0;
      scalar_q      <= '0;
      op_q          <= '0;
      beat_q        <= '0;
      res_cnt_q     <= '0;
      issue_valid_q <= 1'b0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
      vec_a_q       <= '0;
      vec_b_q       <= '0;
    end else begin
      we_q <= 1'b0;
      if (res_fire) begin
        for (int k = 0; k < LANES; k++) begin
          wd_q[(int'(res_cnt_q) + BEATS*k)*L +: L] <= bus.Res_i[k*L +: L];
        end
        res_cnt_q <= res_cnt_q + 3'd1;
      end
      case (state_q)
        IDLE: begin
          if (bus.Start_i) begin
            a_q           <= bus.RD1_VEC_i;
            b_q           <= bus.RD2_VEC_i;
            scalar_q      <= bus.Scalar_i[L-1:0];
            op_q          <= bus.OpType_i;
            beat_q        <= '0;
            res_cnt_q     <= '0;
            vec_a_q       <= vec_a_d;
            vec_b_q       <= vec_b_d;
            issue_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_last) begin
            issue_valid_q <= 1'b0;
            if (res_last) begin
              we_q    <= 1'b1;
              state_q <= WRITE;
            end else begin
              state_q <= DRAIN;
            end
          end else if (issue_fire) begin
            beat_q  <= beat_d;
            vec_a_q <= vec_a_d;
            vec_b_q <= vec_b_d;
          end
        end
        DRAIN: begin
          if (res_last) begin
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Vec_A_o       = vec_a_q;
  assign bus.Vec_B_o       = vec_b_q;
  assign bus.Op_o          = op_q;
  assign bus.Issue_valid_o = issue_valid_q;
  assign bus.Beat_o        = beat_q;
  assign bus.WD_VEC_o      = wd_q;
  assign bus.WE_o          = we_q;
  assign bus.Busy_o        = busy_q;
endmodule
`default_nettype wire
